// File: rtl/morse_tx.sv
// Morse code transmitter: accepts 6-bit character codes over valid/ready and
// keys key_out with standard dot/dash unit timing from an internal pattern ROM.
module morse_tx #(
    parameter int UNIT_CYCLES = 12_000_000,
    parameter int CNT_W       = $clog2(7 * UNIT_CYCLES + 1)
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [5:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       char_err
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_e;

    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(4 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [5:0]       WORD_CODE = 6'd36;

    // {len[2:0], pat[4:0]}; elements are sent from pat[len-1] down to pat[0], 1 = dash.
    function automatic logic [7:0] morse_rom(input logic [5:0] code);
        logic [7:0] entry;
        entry = 8'h00;
        case (code)
            6'd0:  entry = {3'd2, 5'b00001}; // A
            6'd1:  entry = {3'd4, 5'b01000}; // B
            6'd2:  entry = {3'd4, 5'b01010}; // C
            6'd3:  entry = {3'd3, 5'b00100}; // D
            6'd4:  entry = {3'd1, 5'b00000}; // E
            6'd5:  entry = {3'd4, 5'b00010}; // F
            6'd6:  entry = {3'd3, 5'b00110}; // G
            6'd7:  entry = {3'd4, 5'b00000}; // H
            6'd8:  entry = {3'd2, 5'b00000}; // I
            6'd9:  entry = {3'd4, 5'b00111}; // J
            6'd10: entry = {3'd3, 5'b00101}; // K
            6'd11: entry = {3'd4, 5'b00100}; // L
            6'd12: entry = {3'd2, 5'b00011}; // M
            6'd13: entry = {3'd2, 5'b00010}; // N
            6'd14: entry = {3'd3, 5'b00111}; // O
            6'd15: entry = {3'd4, 5'b00110}; // P
            6'd16: entry = {3'd4, 5'b01101}; // Q
            6'd17: entry = {3'd3, 5'b00010}; // R
            6'd18: entry = {3'd3, 5'b00000}; // S
            6'd19: entry = {3'd1, 5'b00001}; // T
            6'd20: entry = {3'd3, 5'b00001}; // U
            6'd21: entry = {3'd4, 5'b00001}; // V
            6'd22: entry = {3'd3, 5'b00011}; // W
            6'd23: entry = {3'd4, 5'b01001}; // X
            6'd24: entry = {3'd4, 5'b01011}; // Y
            6'd25: entry = {3'd4, 5'b01100}; // Z
            6'd26: entry = {3'd5, 5'b11111}; // 0
            6'd27: entry = {3'd5, 5'b01111}; // 1
            6'd28: entry = {3'd5, 5'b00111}; // 2
            6'd29: entry = {3'd5, 5'b00011}; // 3
            6'd30: entry = {3'd5, 5'b00001}; // 4
            6'd31: entry = {3'd5, 5'b00000}; // 5
            6'd32: entry = {3'd5, 5'b10000}; // 6
            6'd33: entry = {3'd5, 5'b11000}; // 7
            6'd34: entry = {3'd5, 5'b11100}; // 8
            6'd35: entry = {3'd5, 5'b11110}; // 9
            default: entry = 8'h00;
        endcase
        return entry;
    endfunction

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pat_q, pat_d;
    logic [2:0]       idx_q, idx_d;
    logic             err_q, err_d;

    logic             accept;
    logic [7:0]       rom_entry;
    logic [2:0]       first_idx;

    // Reset asserts asynchronously but releases in step with the clock.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100MHz or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign accept    = char_valid && char_ready;
    assign rom_entry = morse_rom(char_data);
    assign first_idx = rom_entry[7:5] - 3'd1;

    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        err_d   = 1'b0;

        case (state_q)
            MARK: begin
                if (cnt_q == '0) begin
                    if (idx_q == 3'd0) begin
                        state_d = CHAR_GAP;
                        cnt_d   = DASH_CNT;
                    end else begin
                        state_d = ELEM_GAP;
                        cnt_d   = DOT_CNT;
                        idx_d   = idx_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ELEM_GAP: begin
                if (cnt_q == '0) begin
                    state_d = MARK;
                    cnt_d   = pat_q[idx_q] ? DASH_CNT : DOT_CNT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: ;
        endcase

        // A new character may start straight out of the last gap cycle.
        if (accept) begin
            if (char_data < WORD_CODE) begin
                state_d = MARK;
                pat_d   = rom_entry[4:0];
                idx_d   = first_idx;
                cnt_d   = rom_entry[first_idx] ? DASH_CNT : DOT_CNT;
            end else if (char_data == WORD_CODE) begin
                state_d = WORD_GAP;
                cnt_d   = WORD_CNT;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        key_out    = (state_q == MARK);
        busy       = (state_q != IDLE);
        char_ready = (state_q == IDLE) ||
                     (((state_q == CHAR_GAP) || (state_q == WORD_GAP)) && (cnt_q == '0));
        char_err   = err_q;
    end

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx: directed and random character streams compared
// cycle by cycle against a waveform built from textual dot/dash patterns.
module tb_morse_tx;

    localparam int U = 4;

    typedef bit bitq_t[$];

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic [5:0] char_data  = 6'd0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       char_err;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    morse_tx #(.UNIT_CYCLES(U)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .char_err   (char_err)
    );

    string morse_tab [36] = '{
        ".-",    "-...",  "-.-.",  "-..",   ".",     "..-.",  "--.",   "....",
        "..",    ".---",  "-.-",   ".-..",  "--",    "-.",    "---",   ".--.",
        "--.-",  ".-.",   "...",   "-",     "..-",   "...-",  ".--",   "-..-",
        "-.--",  "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    // Key level for every cycle from the one after acceptance until the block can accept again.
    function automatic bitq_t expected_wave(input int code);
        bitq_t q;
        string s;
        q = {};
        if (code == 36) begin
            repeat (4 * U) q.push_back(1'b0);
        end else if (code < 36) begin
            s = morse_tab[code];
            for (int e = 0; e < s.len(); e++) begin
                repeat ((s[e] == "-") ? 3 * U : U) q.push_back(1'b1);
                repeat ((e == s.len() - 1) ? 3 * U : U) q.push_back(1'b0);
            end
        end
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && char_ready !== 1'b1; i++) tick();
        check("ready_wait", char_ready, 1);
    endtask

    // Sends codes back-to-back with char_valid held; the next code is presented while busy.
    task automatic stream(input int codes[$]);
        bitq_t w;
        char_data  = 6'(codes[0]);
        char_valid = 1'b1;
        wait_ready();
        for (int k = 0; k < codes.size(); k++) begin
            w = expected_wave(codes[k]);
            tick();
            if (k + 1 < codes.size()) begin
                char_data = 6'(codes[k + 1]);
            end else begin
                char_valid = 1'b0;
                char_data  = 6'($urandom);
            end
            if (w.size() == 0) begin
                check($sformatf("err_pulse c%0d", codes[k]), char_err, 1);
                check($sformatf("err_key c%0d", codes[k]), key_out, 0);
                check($sformatf("err_ready c%0d", codes[k]), char_ready, 1);
                check($sformatf("err_busy c%0d", codes[k]), busy, 0);
            end else begin
                for (int i = 0; i < w.size(); i++) begin
                    if (i > 0) tick();
                    check($sformatf("key c%0d i%0d", codes[k], i), key_out, w[i]);
                    check($sformatf("busy c%0d i%0d", codes[k], i), busy, 1);
                    check($sformatf("ready c%0d i%0d", codes[k], i), char_ready,
                          (i == w.size() - 1));
                    if (i == 0) check($sformatf("err_quiet c%0d", codes[k]), char_err, 0);
                end
            end
        end
        tick();
        check("idle_busy", busy, 0);
        check("idle_err", char_err, 0);
        check("idle_key", key_out, 0);
        check("idle_ready", char_ready, 1);
    endtask

    initial begin
        int q[$];

        repeat (3) tick();
        check("rst_key", key_out, 0);
        check("rst_ready", char_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", char_err, 0);
        reset_n = 1'b1;
        repeat (4) tick();

        q = {0};      stream(q);
        q = {26};     stream(q);
        q = {4, 4};   stream(q);
        q = {36};     stream(q);
        q = {40};     stream(q);
        q = {40, 0, 36, 63, 31}; stream(q);

        // Reset in the middle of the dash of 'T'.
        char_data  = 6'd19;
        char_valid = 1'b1;
        wait_ready();
        tick();
        char_valid = 1'b0;
        repeat (5) tick();
        check("t_dash_key", key_out, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_key", key_out, 0);
        check("midrst_ready", char_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        q = {4}; stream(q);

        for (int s = 0; s < 10; s++) begin
            q = {};
            repeat ($urandom_range(1, 4)) q.push_back(int'($urandom_range(0, 63)));
            stream(q);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
